// File: rtl/counter_updown_mod.sv
// ============================================================================
// Module   : counter_updown_mod
// Purpose  : Parametrised up/down counter with load, run-time limit, wrap or
//            saturate mode, registered terminal-count pulse and zero flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_updown_mod #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             ST,
  input  logic [WIDTH-1:0] X,
  input  logic             UP,
  input  logic             MODE,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] OUT,
  output logic             TC,
  output logic             ZF
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] cnt_next;
  logic             tc_next;

  always_comb begin
    cnt_next = OUT;
    tc_next  = 1'b0;
    if (ST) begin
      cnt_next = (X > LIMIT) ? LIMIT : X;
    end else if (EN) begin
      if (UP) begin
        if (OUT < LIMIT) begin
          cnt_next = OUT + ONE;
        end else begin
          cnt_next = MODE ? LIMIT : ZERO;
          tc_next  = 1'b1;
        end
      end else begin
        // A count left above a freshly lowered LIMIT snaps back into range.
        if (OUT > LIMIT) begin
          cnt_next = LIMIT;
        end else if (OUT != ZERO) begin
          cnt_next = OUT - ONE;
        end else begin
          cnt_next = MODE ? ZERO : LIMIT;
          tc_next  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT <= RESET_VAL;
      TC  <= 1'b0;
    end else begin
      OUT <= cnt_next;
      TC  <= tc_next;
    end
  end

  assign ZF = (OUT == ZERO);

endmodule

`default_nettype wire
